// File: rtl/uart_rx_os16.sv
// rtl/uart_rx_os16.sv - 16x oversampling UART receiver with valid/ready byte delivery
//
// Recovers asynchronous serial frames (start, DATA_BITS data bits LSB first,
// optional parity bit, one stop bit) from rx_in. All bit timing advances on
// the one-cycle baud16_tick strobe. Completed bytes are presented on rx_data
// and held with rx_valid until the consumer accepts them.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined     - one parity bit follows the data bits, checked per PARITY_ODD
//                 (0 = even, 1 = odd); parity_err is live.
//   not defined - N-1 frames, parity_err is tied to 0.
//
// Ports:
//   clk50m       in   system clock
//   reset        in   synchronous, active-high reset
//   baud16_tick  in   one-cycle strobe at 16x the baud rate
//   rx_in        in   asynchronous serial line, idles at 1
//   rx_data      out  received byte, bits above DATA_BITS-1 read 0
//   rx_valid     out  rx_data holds an unconsumed byte
//   rx_ready     in   consumer accepts on rx_valid && rx_ready
//   frame_err    out  one-cycle pulse: stop bit sampled as 0
//   parity_err   out  one-cycle pulse: parity mismatch
//   overrun_err  out  one-cycle pulse: a completed byte was dropped
//   rx_busy      out  receiver is inside a frame (any state except idle)

module uart_rx_os16 #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk50m,
    input  logic       reset,
    input  logic       baud16_tick,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun_err,
    output logic       rx_busy
);

    if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_rx_os16: DATA_BITS must be 5..8 and PARITY_ODD 0 or 1");
    end

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd5;
`endif

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    // Bits enter at the top of shreg, so after DATA_BITS samples the frame
    // occupies the upper DATA_BITS positions; shifting down right-justifies
    // it and zero-fills the unused upper bits.
    localparam int ALIGN = 8 - DATA_BITS;

    logic       rx_meta;
    logic       rxs;
    logic [2:0] state;
    logic [3:0] cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] data_word;
    logic       par_ok;

    assign data_word = shreg >> ALIGN;
    assign rx_busy   = (state != ST_IDLE);

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    // Data bits XOR parity bit equals 0 for even parity, 1 for odd parity.
    assign par_ok = ((^data_word) ^ par_bit) == PARITY_ODD[0];
`else
    assign par_ok     = 1'b1;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk50m) begin
        if (reset) begin
            rx_meta     <= 1'b1;
            rxs         <= 1'b1;
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            bit_cnt     <= 3'd0;
            shreg       <= 8'h00;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit     <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            rx_meta     <= rx_in;
            rxs         <= rx_meta;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
            // A delivery later in this block overrides this clear, which is
            // how accept and load in the same cycle keep rx_valid high.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (baud16_tick) begin
                cnt <= cnt + 4'd1;
                case (state)
                    ST_IDLE: begin
                        if (!rxs) begin
                            state <= ST_START;
                            cnt   <= 4'd0;
                        end
                    end
                    ST_START: begin
                        if (cnt == 4'd7) begin
                            if (rxs) begin
                                state <= ST_IDLE;
                            end else begin
                                cnt     <= 4'd0;
                                bit_cnt <= 3'd0;
                                state   <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (cnt == 4'd15) begin
                            shreg   <= {rxs, shreg[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                                state <= ST_PARITY;
`else
                                state <= ST_STOP;
`endif
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    ST_PARITY: begin
                        if (cnt == 4'd15) begin
                            par_bit <= rxs;
                            state   <= ST_STOP;
                        end
                    end
`endif
                    ST_STOP: begin
                        if (cnt == 4'd15) begin
`ifdef UART_RX_PARITY_EN
                            parity_err <= !par_ok;
`endif
                            if (rxs) begin
                                // Returning to idle at mid-stop lets the next
                                // start edge be caught without a gap.
                                state <= ST_IDLE;
                                if (par_ok) begin
                                    if (!rx_valid || rx_ready) begin
                                        rx_data  <= data_word;
                                        rx_valid <= 1'b1;
                                    end else begin
                                        overrun_err <= 1'b1;
                                    end
                                end
                            end else begin
                                frame_err <= 1'b1;
                                state     <= ST_BREAK;
                            end
                        end
                    end
                    ST_BREAK: begin
                        // A held-low line stays here so it reports only once.
                        if (rxs) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
